// File: rtl/score_incrementer_if.sv
// ============================================================================
//  Module   : score_incrementer_if
//  Purpose  : Add-request handshake between collision logic and the score
//             accumulator (valid/ready with an amount payload).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface score_incrementer_if #(
  parameter int AMT_W = 4
) ();
  logic             add_valid;
  logic [AMT_W-1:0] add_amount;
  logic             add_ready;

  // Requester side (collision logic)
  modport master (
    output add_valid,
    output add_amount,
    input  add_ready
  );

  // Accumulator side
  modport slave (
    input  add_valid,
    input  add_amount,
    output add_ready
  );
endinterface

`default_nettype wire

// File: rtl/score_incrementer.sv
// ============================================================================
//  Module   : score_incrementer
//  Purpose  : BCD score accumulator. Accepts add requests, counts the score
//             up one unit per clock, saturates at all-9s and pulses life_up
//             whenever a carry enters digit LIFE_DIGIT.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_incrementer #(
  parameter int DIGITS     = 4,
  parameter int AMT_W      = 4,
  parameter int LIFE_DIGIT = 3
) (
  input  logic                  clock,
  input  logic                  clr_n,
  input  logic                  ld,
  input  logic [4*DIGITS-1:0]   D,
  score_incrementer_if.slave    add_if,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  life_up,
  output logic                  sat
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_COUNT = 1'b1;
  localparam logic [3:0] C_NINE  = 4'd9;

  logic [0:0]          state_q, state_d;
  logic [AMT_W-1:0]    rem_q, rem_d;
  logic [4*DIGITS-1:0] score_q, score_d;
  logic                life_q, life_d;

  logic [4*DIGITS-1:0] w_inc;
  logic [4*DIGITS-1:0] w_clamp;
  logic [DIGITS-1:0]   w_nine;
  logic [DIGITS-1:0]   w_carry;
  logic                w_ready;

  // w_carry[i] is the carry entering digit i on a +1 step; digit 0 always
  // receives the increment itself.
  assign w_carry[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign w_nine[i] = (score_q[4*i +: 4] == C_NINE);

    assign w_inc[4*i +: 4] = !w_carry[i] ? score_q[4*i +: 4] :
                             (w_nine[i]  ? 4'd0 : score_q[4*i +: 4] + 4'd1);

    // Non-BCD load nibbles are clamped to 9 so Q always holds legal BCD.
    assign w_clamp[4*i +: 4] = (D[4*i +: 4] > C_NINE) ? C_NINE : D[4*i +: 4];

    if (i < DIGITS - 1) begin : g_chain
      assign w_carry[i+1] = w_carry[i] & w_nine[i];
    end
  end

  assign sat     = &w_nine;
  assign Q       = score_q;
  assign life_up = life_q;

  // State register: all sequential state, synchronous active-low clear.
  always_ff @(posedge clock) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      score_q <= '0;
      life_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      score_q <= score_d;
      life_q  <= life_d;
    end
  end

  // Next-state logic: load overrides counting; saturation drops the remainder.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    score_d = score_q;
    life_d  = 1'b0;
    if (ld) begin
      score_d = w_clamp;
      rem_d   = '0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (add_if.add_valid && w_ready && (add_if.add_amount != '0)) begin
            rem_d   = add_if.add_amount;
            state_d = S_COUNT;
          end
        end
        S_COUNT: begin
          if (sat) begin
            rem_d   = '0;
            state_d = S_IDLE;
          end else begin
            score_d = w_inc;
            rem_d   = rem_q - AMT_W'(1);
            life_d  = w_carry[LIFE_DIGIT];
            if (rem_q == AMT_W'(1)) begin
              state_d = S_IDLE;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          rem_d   = '0;
        end
      endcase
    end
  end

  // Output logic: ready only when idle and no load is being applied.
  always_comb begin
    w_ready = (state_q == S_IDLE) && !ld;
  end

  assign add_if.add_ready = w_ready;

endmodule

`default_nettype wire

// File: tb/tb_score_incrementer.sv
// ============================================================================
//  Module   : tb_score_incrementer
//  Purpose  : Self-checking bench for score_incrementer. An integer score
//             model predicts every Q change; a monitor compares each change.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_incrementer;
  localparam int DIGITS     = 4;
  localparam int AMT_W      = 4;
  localparam int LIFE_DIGIT = 3;
  localparam int MAXV       = 9999;
  localparam int LIFE_MOD   = 1000;

  logic        clock = 1'b0;
  logic        clr_n = 1'b0;
  logic        ld    = 1'b0;
  logic [15:0] D     = 16'h0;
  logic [15:0] Q;
  logic        life_up;
  logic        sat;

  score_incrementer_if #(.AMT_W(AMT_W)) bus ();

  score_incrementer #(
    .DIGITS(DIGITS), .AMT_W(AMT_W), .LIFE_DIGIT(LIFE_DIGIT)
  ) dut (
    .clock(clock), .clr_n(clr_n), .ld(ld), .D(D),
    .add_if(bus), .Q(Q), .life_up(life_up), .sat(sat)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] q;
    bit          life;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          score  = 0;
  bit          mon_en = 1'b0;
  logic [15:0] last_q;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int clamp_val(input logic [15:0] d);
    int v, p, dg;
    v = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      dg = int'(d[4*i +: 4]);
      if (dg > 9) dg = 9;
      v = v + dg * p;
      p = p * 10;
    end
    return v;
  endfunction

  function automatic void push(input int v, input bit life);
    exp_t e;
    e.q    = to_bcd(v);
    e.life = life;
    sb.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Monitor: every change of Q must match the next predicted value.
  always @(negedge clock) begin
    if (mon_en) begin
      if (Q !== last_q) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL q_change: got Q=%h life_up=%b, required Q to stay %h", Q, life_up, last_q);
        end else begin
          mon_e = sb.pop_front();
          if (Q !== mon_e.q || life_up !== mon_e.life) begin
            errors++;
            $display("FAIL q_step: got Q=%h life_up=%b, required Q=%h life_up=%b",
                     Q, life_up, mon_e.q, mon_e.life);
          end
        end
      end else if (life_up !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL life_up_spurious: got life_up=%b with Q=%h, required 0", life_up, Q);
      end
      last_q = Q;
    end
  end

  task automatic wait_ready();
    int t;
    t = 0;
    while (bus.add_ready !== 1'b1 && t < 100) begin
      @(negedge clock);
      t++;
    end
    chk("ready_before_req", 32'(bus.add_ready), 32'd1);
  endtask

  // Full add request; entered and left on a falling edge.
  task automatic do_add(input int n);
    int s, expc, cnt;
    wait_ready();
    bus.add_valid  = 1'b1;
    bus.add_amount = 4'(n);
    @(posedge clock);
    #1;
    bus.add_valid  = 1'b0;
    bus.add_amount = 4'($urandom);
    s = 0;
    for (int k = 0; k < n; k++) begin
      if (score == MAXV) break;
      score++;
      s++;
      push(score, (score % LIFE_MOD) == 0);
    end
    expc = (s < n) ? s + 1 : n;
    cnt  = 0;
    forever begin
      @(negedge clock);
      if (bus.add_ready === 1'b1 || cnt >= 100) break;
      cnt++;
    end
    chk("ready_low_cycles", 32'(cnt), 32'(expc));
    chk("sat_after_add", 32'(sat), 32'(score == MAXV));
  endtask

  // Load, optionally with a concurrent add request that must be refused.
  task automatic do_ld(input logic [15:0] val, input bit with_valid);
    int nv;
    bus.add_valid  = with_valid;
    bus.add_amount = 4'd4;
    ld = 1'b1;
    D  = val;
    #1;
    chk("ready_during_ld", 32'(bus.add_ready), 32'd0);
    nv = clamp_val(val);
    if (nv != score) push(nv, 1'b0);
    score = nv;
    @(posedge clock);
    #1;
    ld = 1'b0;
    bus.add_valid = 1'b0;
    @(negedge clock);
    chk("q_after_ld", 32'(Q), 32'(to_bcd(score)));
    chk("ready_after_ld", 32'(bus.add_ready), 32'd1);
    chk("sat_after_ld", 32'(sat), 32'(score == MAXV));
  endtask

  // Add request aborted by reset (use_ld=0) or load at the k-th count edge.
  task automatic do_add_abort(input int n, input int k, input bit use_ld, input logic [15:0] val);
    int nv;
    wait_ready();
    bus.add_valid  = 1'b1;
    bus.add_amount = 4'(n);
    @(posedge clock);
    #1;
    bus.add_valid = 1'b0;
    for (int j = 1; j < k; j++) begin
      score++;
      push(score, (score % LIFE_MOD) == 0);
    end
    repeat (k - 1) @(posedge clock);
    #1;
    if (use_ld) begin
      ld = 1'b1;
      D  = val;
      nv = clamp_val(val);
    end else begin
      clr_n = 1'b0;
      nv    = 0;
    end
    if (nv != score) push(nv, 1'b0);
    score = nv;
    @(posedge clock);
    #1;
    ld    = 1'b0;
    clr_n = 1'b1;
    @(negedge clock);
    chk("q_after_abort", 32'(Q), 32'(to_bcd(score)));
    chk("ready_after_abort", 32'(bus.add_ready), 32'd1);
    chk("life_after_abort", 32'(life_up), 32'd0);
  endtask

  initial begin
    int r;
    bus.add_valid  = 1'b0;
    bus.add_amount = '0;
    repeat (3) @(posedge clock);
    #1;
    clr_n = 1'b1;
    @(negedge clock);
    chk("reset_q", 32'(Q), 32'd0);
    chk("reset_life", 32'(life_up), 32'd0);
    chk("reset_sat", 32'(sat), 32'd0);
    chk("reset_ready", 32'(bus.add_ready), 32'd1);
    last_q = Q;
    mon_en = 1'b1;

    do_add(5);
    do_ld(16'h0998, 1'b0);
    do_add(3);
    do_ld(16'h9997, 1'b0);
    do_add(5);
    do_add(4);
    do_ld(16'h0000, 1'b0);
    do_add_abort(15, 4, 1'b0, 16'h0000);
    do_ld(16'hA5F3, 1'b1);
    repeat (5) @(negedge clock);
    chk("q_stable_after_ld", 32'(Q), 32'h9593);
    do_add(0);
    do_add(2);
    do_add(2);
    do_add_abort(6, 2, 1'b1, 16'h1234);

    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2) begin
        do_ld(16'($urandom), 1'b0);
      end else if (r < 4) begin
        do_ld(to_bcd(int'($urandom_range(0, 9)) * 1000 + 990 + int'($urandom_range(0, 9))), 1'b0);
      end else begin
        do_add(int'($urandom_range(0, 15)));
      end
    end

    repeat (5) @(negedge clock);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/score_incrementer.md
Name: score_incrementer

Overview:
- BCD score accumulator for the asteroids game; the up-counting counterpart of the lives decrementer.
- Collision logic issues add requests (points per destroyed asteroid) over a valid/ready handshake.
- The block counts the score up one unit per clock, saturating at all-9s.
- It emits a one-cycle life_up pulse on every crossing of a configurable decade boundary; that pulse feeds the lives counter's load path to grant extra lives.

Parameters:
- DIGITS, 4: number of BCD digits in Q.
- AMT_W, 4: width of add_amount (max single request 2^AMT_W-1).
- LIFE_DIGIT, 3: digit index whose carry-in triggers life_up (3 = every 1000 points); must be < DIGITS.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- clr_n  input  1  synchronous, active-low reset.
- ld  input  1  synchronous load of D into Q.
- D  input  4*DIGITS  BCD load value, digit 0 in bits [3:0].
- add_valid  input  1  add request valid.
- add_amount  input  AMT_W  units to add.
- add_ready  output  1  block can accept a request.
- Q  output  4*DIGITS  current BCD score, registered.
- life_up  output  1  one-cycle pulse per LIFE_DIGIT carry-in.
- sat  output  1  high while Q is all 9s.

Behaviour:
- Priority per rising edge: clr_n low > ld > add accept/count.
- Reset (clr_n low at edge): Q=0, state IDLE, remaining=0, life_up=0. Consequently sat=0 and add_ready=1 from the following cycle. Reset mid-COUNT discards the pending amount.
- States: IDLE, COUNT.
  - remaining register is AMT_W bits.
  - add_ready = (state==IDLE) && !ld, combinational.
- IDLE, handshake add_valid && add_ready:
  - add_amount==0: accepted, no change, stay IDLE.
  - Otherwise: remaining <= add_amount, go COUNT. Q does not change on the accept edge.
- COUNT, each edge:
  - If sat: Q holds, remaining <= 0, go IDLE. The unconsumed amount is dropped.
  - Else: Q <= Q+1 in BCD (digit 9 wraps to 0 with carry into the next digit), remaining <= remaining-1.
  - If remaining was 1: go IDLE.
- Latency: a request of N (no saturation) holds add_ready low for N cycles. Q reaches old+N on the N-th edge after accept, and add_ready is high the cycle after.
- life_up: registered. High for exactly the one cycle in which Q first shows a value produced by a carry into digit LIFE_DIGIT. Low otherwise, including on ld and reset. Carries out of the top digit cannot occur (saturation).
- sat: combinational, (all digits == 9). It is independent of state.
- ld at an edge: Q <= D with each digit >9 clamped to 9, remaining <= 0, state IDLE, life_up <= 0.
  - ld during COUNT aborts the request.
  - ld concurrent with add_valid in IDLE: no accept, since add_ready is low.
- add_valid while add_ready is low is ignored. The requester must hold the request until add_ready is high.

Test Plan:
- Reset, then add_amount=5 with add_valid for one cycle: add_ready low 5 cycles; Q steps 0001..0005; add_ready high the next cycle; life_up never high.
- ld D=0998, then add 3: Q=0999, 1000, 1001 on consecutive edges; life_up high only in the cycle Q=1000.
- ld D=9997, then add 5: Q=9998, 9999, then holds 9999; state IDLE after at most 3 COUNT edges; sat=1; add_ready high.
- Add 15 from 0; drive clr_n low at the 4th count edge: Q=0000 after that edge, add_ready=1 next cycle, life_up=0.
- ld=1 and add_valid=1 with add_amount=4 on the same edge, D=0xA5F3: Q=9593, no request accepted, Q stable afterwards.
- add_amount=0 with add_valid: accepted, Q unchanged, add_ready never drops; back-to-back add 2, add 2 yields Q +4 after 4 count cycles plus accept gaps.
